// File: rtl/setuphold_mon_pkg.sv
// ---------------------------------------------------------------------------
// setuphold_mon_pkg
//   Shared definitions for the setuphold_monitor block:
//     - EDGE_RISE / EDGE_FALL : values for the EDGE parameter
//     - tmr_width()           : width of the age / hold timers
//     - SHM_CHECK_RANGE       : elaboration-time parameter range check
// ---------------------------------------------------------------------------
package setuphold_mon_pkg;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;

  // Timers count up to max(SETUP, HOLD) and must also hold that value.
  function automatic int tmr_width(input int setup, input int hold);
    int m;
    m = (setup > hold) ? setup : hold;
    return $clog2(m + 1);
  endfunction

endpackage

// Generate-scope check: raises an elaboration error when val is outside lo..hi.
`ifndef SHM_CHECK_RANGE
`define SHM_CHECK_RANGE(lbl, val, lo, hi) \
  if (((val) < (lo)) || ((val) > (hi))) begin : lbl \
    $error("setuphold_monitor: parameter out of range"); \
  end
`endif

// File: rtl/setuphold_mon_chan.sv
// ---------------------------------------------------------------------------
// setuphold_mon_chan
//   One monitored data line: input register, change detect, age counter,
//   setup/hold decision, notifier and (optionally) saturating counter.
//   Optional feature macro: SETUPHOLD_MON_COUNT_EN (counter present when
//   defined; otherwise cnt_o is tied to zero and clr_i is ignored).
//
//   clk, rst_n    : sampling clock, synchronous active-low reset
//   en_i          : registered check enable from the top
//   prime_i       : first cycle after reset, suppresses change detection
//   ref_edge_i    : active reference edge detected this cycle
//   hold_open_i   : shared hold window still open this cycle
//   clr_i         : registered counter clear
//   data_i        : raw data line
//   setup_viol_o  : one-cycle setup-violation pulse
//   hold_viol_o   : one-cycle hold-violation pulse
//   notifier_o    : toggles on every violation
//   cnt_o         : saturating violation count
// ---------------------------------------------------------------------------
module setuphold_mon_chan
  import setuphold_mon_pkg::*;
#(
  parameter int SETUP = 2,
  parameter int CNT_W = 8,
  parameter int TW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             prime_i,
  input  logic             ref_edge_i,
  input  logic             hold_open_i,
  input  logic             clr_i,
  input  logic             data_i,
  output logic             setup_viol_o,
  output logic             hold_viol_o,
  output logic             notifier_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [TW-1:0] SETUP_V  = TW'(SETUP);
  localparam logic [TW-1:0] SETUP_M1 = TW'(SETUP - 1);

  logic          data_q, data_prev_q;
  logic          chg;
  logic [TW-1:0] age_q, age_d;
  logic          setup_q, setup_d;
  logic          hold_q, hold_d;
  logic          notif_q, notif_d;

  always_ff @(posedge clk) begin
    data_q      <= data_i;
    data_prev_q <= data_q;
  end

  assign chg = (data_q ^ data_prev_q) & ~prime_i;

  always_comb begin
    // age = cycles since the last data change, saturating at SETUP so a line
    // that has been quiet long enough never trips the setup check.
    age_d = age_q;
    if (chg)                   age_d = '0;
    else if (age_q != SETUP_V) age_d = age_q + TW'(1);

    // age_q is the pre-increment value: a change k cycles before the edge
    // leaves age_q = k-1 here, so k < SETUP maps to age_q < SETUP-1.
    setup_d = en_i & ref_edge_i & (chg | (age_q < SETUP_M1));
    // A change coinciding with a (re)load edge is reported as setup only.
    hold_d  = en_i & chg & ~ref_edge_i & hold_open_i;
    notif_d = notif_q ^ (setup_d | hold_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      age_q   <= SETUP_V;
      setup_q <= 1'b0;
      hold_q  <= 1'b0;
      notif_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      setup_q <= setup_d;
      hold_q  <= hold_d;
      notif_q <= notif_d;
    end
  end

  assign setup_viol_o = setup_q;
  assign hold_viol_o  = hold_q;
  assign notifier_o   = notif_q;

`ifdef SETUPHOLD_MON_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                                   cnt_d = '0;
    else if ((setup_d | hold_d) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_i;
  assign cnt_o      = '0;
`endif

endmodule

// File: rtl/setuphold_monitor.sv
// ---------------------------------------------------------------------------
// setuphold_monitor
//   Cycle-based setup/hold checker. Samples a reference strobe and CHANNELS
//   data lines on clk and flags data changes inside the SETUP window before
//   or the HOLD window after the active (EDGE) reference edge.
//   Optional feature macro: SETUPHOLD_MON_COUNT_EN enables the per-channel
//   saturating counters and cnt_clr; without it viol_cnt reads zero.
//
//   clk        : sampling clock
//   rst_n      : synchronous active-low reset
//   en         : check enable (age tracking continues while low)
//   ref_sig    : monitored reference strobe
//   data       : monitored data lines
//   cnt_clr    : synchronous clear of all violation counters
//   setup_viol : per-channel one-cycle setup-violation pulse
//   hold_viol  : per-channel one-cycle hold-violation pulse
//   notifier   : per-channel toggle on every violation
//   viol_cnt   : per-channel saturating counts, channel 0 in the LSBs
// ---------------------------------------------------------------------------
module setuphold_monitor
  import setuphold_mon_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SETUP    = 2,
  parameter int HOLD     = 3,
  parameter int EDGE     = EDGE_RISE,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      ref_sig,
  input  logic [CHANNELS-1:0]       data,
  input  logic                      cnt_clr,
  output logic [CHANNELS-1:0]       setup_viol,
  output logic [CHANNELS-1:0]       hold_viol,
  output logic [CHANNELS-1:0]       notifier,
  output logic [CHANNELS*CNT_W-1:0] viol_cnt
);

  localparam int            TW     = tmr_width(SETUP, HOLD);
  localparam logic [TW-1:0] HOLD_V = TW'(HOLD);

  `SHM_CHECK_RANGE(g_chk_channels, CHANNELS, 1, 32)
  `SHM_CHECK_RANGE(g_chk_setup,    SETUP,    1, 255)
  `SHM_CHECK_RANGE(g_chk_hold,     HOLD,     1, 255)
  `SHM_CHECK_RANGE(g_chk_edge,     EDGE,     0, 1)
  `SHM_CHECK_RANGE(g_chk_cnt_w,    CNT_W,    1, 16)

  logic          ref_q, ref_prev_q;
  logic          en_q, clr_q;
  logic          prime_q;
  logic          ref_raw, ref_edge;
  logic [TW-1:0] hold_tmr_q, hold_tmr_d;

  // NOTE: the input sample flops carry no reset on purpose; prime_q masks the
  // one cycle in which the previous sample is stale, and a reset here would
  // instead manufacture an edge against the reset value.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop sees
    // the pre-edge value of its neighbours (ref_prev_q takes the old ref_q).
    ref_q      <= ref_sig;
    ref_prev_q <= ref_q;
    en_q       <= en;
    clr_q      <= cnt_clr;
  end

  assign ref_raw  = (EDGE == EDGE_RISE) ? (ref_q & ~ref_prev_q) : (~ref_q & ref_prev_q);
  assign ref_edge = ref_raw & ~prime_q;

  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    hold_tmr_d = hold_tmr_q;
    if (!en_q)                   hold_tmr_d = '0;
    else if (ref_edge)           hold_tmr_d = HOLD_V;  // also reloads an open window
    else if (hold_tmr_q != '0)   hold_tmr_d = hold_tmr_q - TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prime_q    <= 1'b1;
      hold_tmr_q <= '0;
    end else begin
      prime_q    <= 1'b0;
      hold_tmr_q <= hold_tmr_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    setuphold_mon_chan #(
      .SETUP (SETUP),
      .CNT_W (CNT_W),
      .TW    (TW)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (en_q),
      .prime_i      (prime_q),
      .ref_edge_i   (ref_edge),
      .hold_open_i  (hold_tmr_q != '0),
      .clr_i        (clr_q),
      .data_i       (data[g]),
      .setup_viol_o (setup_viol[g]),
      .hold_viol_o  (hold_viol[g]),
      .notifier_o   (notifier[g]),
      .cnt_o        (viol_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_setuphold_monitor.sv
// ---------------------------------------------------------------------------
// tb_setuphold_monitor
//   Directed scenarios plus randomized traffic. The reference model keeps the
//   detection-cycle timestamp of the last reference edge, the last change on
//   each data line and the last cycle with enable low, and applies the
//   window rules (r-d < SETUP, 0 < d-r <= HOLD) by plain subtraction.
// ---------------------------------------------------------------------------
module tb_setuphold_monitor;

  localparam int CH      = 4;
  localparam int SETUP   = 2;
  localparam int HOLD    = 3;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int NONE    = -1000000;
`ifdef SETUPHOLD_MON_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n, en, ref_sig, cnt_clr;
  logic [CH-1:0]       data;
  logic [CH-1:0]       setup_viol, hold_viol, notifier;
  logic [CH*CNT_W-1:0] viol_cnt;

  always #5 clk = ~clk;

  setuphold_monitor #(
    .CHANNELS (CH),
    .SETUP    (SETUP),
    .HOLD     (HOLD),
    .EDGE     (1),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ref_sig    (ref_sig),
    .data       (data),
    .cnt_clr    (cnt_clr),
    .setup_viol (setup_viol),
    .hold_viol  (hold_viol),
    .notifier   (notifier),
    .viol_cnt   (viol_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            cyc = 0;
  logic          p_rst = 1'b0, p_en = 1'b0, p_ref = 1'b0, p_clr = 1'b0;
  logic [CH-1:0] p_data = '0;
  logic          pp_ref = 1'b0;
  logic [CH-1:0] pp_data = '0;
  int            last_r = NONE;
  int            last_en_low = NONE;
  int            last_d [CH];
  logic [CH-1:0] exp_setup = '0, exp_hold = '0, exp_notif = '0;
  int            exp_cnt [CH];

  // Called right after each rising edge with the inputs that edge sampled.
  // Produces the outputs expected after this edge from detection cycle cyc-1.
  task automatic model_step();
    int   c;
    logic edge_r, chg, s, h;
    if (!rst_n) begin
      exp_setup = '0; exp_hold = '0; exp_notif = '0;
      last_r = NONE; last_en_low = NONE;
      for (int i = 0; i < CH; i++) begin
        last_d[i] = NONE; exp_cnt[i] = 0;
      end
    end else if (!p_rst) begin
      exp_setup = '0; exp_hold = '0;
      if (p_clr) for (int i = 0; i < CH; i++) exp_cnt[i] = 0;
    end else begin
      c      = cyc - 1;
      edge_r = p_ref && !pp_ref;
      if (!p_en) last_en_low = c;
      for (int i = 0; i < CH; i++) begin
        chg = (p_data[i] != pp_data[i]);
        s   = p_en && edge_r && (chg || (c - last_d[i] < SETUP));
        h   = p_en && chg && !edge_r && (c - last_r <= HOLD) && (last_en_low < last_r);
        exp_setup[i] = s;
        exp_hold[i]  = h;
        if (s || h) exp_notif[i] = ~exp_notif[i];
        if (p_clr)                                   exp_cnt[i] = 0;
        else if (COUNT_EN && (s || h) && exp_cnt[i] < CNT_MAX) exp_cnt[i]++;
        if (chg) last_d[i] = c;
      end
      if (edge_r) last_r = c;
    end
    pp_ref = p_ref; pp_data = p_data;
    p_rst = rst_n; p_en = en; p_ref = ref_sig; p_clr = cnt_clr; p_data = data;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("setup_viol", 32'(setup_viol), 32'(exp_setup));
    check("hold_viol",  32'(hold_viol),  32'(exp_hold));
    check("notifier",   32'(notifier),   32'(exp_notif));
    for (int i = 0; i < CH; i++)
      check($sformatf("viol_cnt%0d", i), 32'(viol_cnt[i*CNT_W +: CNT_W]), 32'(exp_cnt[i]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic tog(input int ch);
    data[ch] = ~data[ch];
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin
      last_d[i] = NONE; exp_cnt[i] = 0;
    end
    rst_n = 1'b0; en = 1'b1; ref_sig = 1'b0; data = '0; cnt_clr = 1'b0;
    idle(3);
    check("reset_notifier", 32'(notifier), 32'd0);
    check("reset_cnt", 32'(viol_cnt), 32'd0);
    rst_n = 1'b1;
    idle(6);

    // data[0] changes one cycle before the rise: setup violation.
    tog(0); tick();
    ref_sig = 1'b1; tick();
    idle(4); ref_sig = 1'b0; idle(6);
    check("t1_notifier0", 32'(notifier[0]), 32'd1);
    check("t1_cnt0", 32'(viol_cnt[0 +: CNT_W]), COUNT_EN ? 32'd1 : 32'd0);

    // data[1] two cycles before and four cycles after: clean.
    tog(1); tick(); tick();
    ref_sig = 1'b1; tick();
    ref_sig = 1'b0; idle(3);
    tog(1); tick(); idle(6);
    check("t2_notifier1", 32'(notifier[1]), 32'd0);

    // data[2] in the same cycle as the rise: setup only.
    tog(2); ref_sig = 1'b1; tick();
    ref_sig = 1'b0; idle(6);
    check("t3_notifier2", 32'(notifier[2]), 32'd1);

    // data[3] at +1 and +3 after the rise: two hold violations.
    ref_sig = 1'b1; tick();
    ref_sig = 1'b0; tog(3); tick();
    tick();
    tog(3); tick(); idle(6);
    check("t4_notifier3", 32'(notifier[3]), 32'd0);
    check("t4_cnt3", 32'(viol_cnt[3*CNT_W +: CNT_W]), COUNT_EN ? 32'd2 : 32'd0);

    // Second rise at +2 reloads the window; data[0] at +4 is a hold violation.
    ref_sig = 1'b1; tick();
    ref_sig = 1'b0; tick();
    ref_sig = 1'b1; tick();
    ref_sig = 1'b0; tick();
    tog(0); tick(); idle(6);
    check("t5_notifier0", 32'(notifier[0]), 32'd0);

    // 300 setup violations on channel 0: counter saturates.
    for (int k = 0; k < 300; k++) begin
      tog(0); ref_sig = 1'b1; tick();
      ref_sig = 1'b0; tick();
    end
    idle(4);
    check("t6_cnt0_sat", 32'(viol_cnt[0 +: CNT_W]), COUNT_EN ? 32'(CNT_MAX) : 32'd0);

    cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0; tick();
    check("t7_cnt_clr", 32'(viol_cnt), 32'd0);
    idle(4);

    // Reset for one cycle inside an open hold window: window discarded.
    ref_sig = 1'b1; tick();
    rst_n = 1'b0; tick();
    check("t8_rst_notifier", 32'(notifier), 32'd0);
    check("t8_rst_cnt", 32'(viol_cnt), 32'd0);
    rst_n = 1'b1;
    tog(0); tick();
    tog(1); tick();
    check("t8_no_hold", 32'(hold_viol), 32'd0);
    ref_sig = 1'b0; idle(6);
    check("t8_notifier", 32'(notifier), 32'd0);

    // Randomized traffic including enable drops, clears and resets.
    for (int k = 0; k < 2000; k++) begin
      rst_n   = ($urandom_range(199) != 0);
      en      = ($urandom_range(15) != 0);
      cnt_clr = ($urandom_range(63) == 0);
      if ($urandom_range(2) == 0) ref_sig = ~ref_sig;
      for (int i = 0; i < CH; i++)
        if ($urandom_range(5) == 0) tog(i);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
